// File: rtl/euler_row_sequencer_pkg.sv
// Shared constants and state encoding for the Euler row sequencer.
// Watchdog support is compiled in only with EULER_SEQ_WDOG_EN.
package euler_row_sequencer_pkg;

    localparam int          STEP_W             = 16;
    localparam int unsigned RES_BASE_DEFAULT   = 0;
    localparam int unsigned WDOG_LIMIT_DEFAULT = 1023;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 3'd0;
    localparam seq_state_t ST_LAUNCH   = 3'd1;
    localparam seq_state_t ST_WAIT     = 3'd2;
    localparam seq_state_t ST_WRITE    = 3'd3;
    localparam seq_state_t ST_STEP_END = 3'd4;
    localparam seq_state_t ST_ABORT    = 3'd5;
    localparam seq_state_t ST_DONE     = 3'd6;

    // ABORT is excluded so a held abort cannot stretch the one-cycle ABORT strobe.
    function automatic logic is_abortable(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_ABORT);
    endfunction

endpackage

// File: rtl/euler_row_sequencer_wdog.sv
// WAIT-state watchdog for the Euler row sequencer; instantiated only when
// EULER_SEQ_WDOG_EN is defined.
module euler_seq_wdog
    import euler_row_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    output logic expired
);

    logic [STEP_W-1:0] cnt_q;
    logic [STEP_W-1:0] cnt_d;

    // Held at zero outside WAIT, so every entry to WAIT starts a fresh count.
    always_comb begin
        cnt_d = '0;
        if (in_wait) begin
            cnt_d = cnt_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = in_wait && ((32'(cnt_q) + 32'd1) == 32'(LIMIT));

endmodule

// File: rtl/euler_row_sequencer.sv
// Sequences the Euler matrix-vector pipeline: one launch per step, one write per row.
// Optional WAIT watchdog enabled by defining EULER_SEQ_WDOG_EN.
module euler_row_sequencer
    import euler_row_sequencer_pkg::*;
#(
    parameter int          ADD_SIZE   = 16,
    parameter int          DATA_SIZE  = 16,
    parameter int          MAX_DIM    = 6,
    parameter int unsigned RES_BASE   = RES_BASE_DEFAULT,
    parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [MAX_DIM-1:0]   shape_0,
    input  logic [MAX_DIM-1:0]   shape_1,
    input  logic [STEP_W-1:0]    n_steps,
    input  logic                 pipe_data_ready,
    input  logic [DATA_SIZE-1:0] pipe_out_acc,
    input  logic                 pipe_overflow,
    output logic                 pipe_start,
    output logic                 pipe_final_done,
    output logic                 pipe_return_default,
    output logic                 wr_en,
    output logic [ADD_SIZE-1:0]  wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic [MAX_DIM-1:0]   row_idx,
    output logic [STEP_W-1:0]    step_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow,
    output logic                 err_timeout,
    output logic [2:0]           state_dbg
);

    // Pipeline handshake: pipe_data_ready/pipe_out_acc is a valid-only
    // offer, taken in exactly the WAIT cycle it is high; the sequencer answers
    // with pipe_return_default in the following (WRITE) cycle as the ready/ack.

    seq_state_t           state_q, state_d;
    logic [MAX_DIM-1:0]   shape0_q, shape0_d;
    logic [STEP_W-1:0]    nsteps_q, nsteps_d;
    logic [MAX_DIM-1:0]   row_q, row_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
    logic                 ovf_q, ovf_d;
    logic                 tmo_q, tmo_d;
    logic                 wdog_expired;
    logic                 last_row;
    logic                 last_step;
    logic                 zero_job;

`ifdef EULER_SEQ_WDOG_EN
    euler_seq_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .in_wait(state_q == ST_WAIT),
        .expired(wdog_expired)
    );
`else
    logic wdog_limit_unused;
    assign wdog_limit_unused = (WDOG_LIMIT != 0);
    assign wdog_expired      = 1'b0;
`endif

    assign last_row  = (row_q == (shape0_q - MAX_DIM'(1)));
    assign last_step = (step_q == (nsteps_q - STEP_W'(1)));
    assign zero_job  = (shape_0 == '0) || (shape_1 == '0) || (n_steps == '0);

    always_comb begin
        state_d   = state_q;
        shape0_d  = shape0_q;
        nsteps_d  = nsteps_q;
        row_d     = row_q;
        step_d    = step_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;

        if (abort && is_abortable(state_q)) begin
            state_d = ST_ABORT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        shape0_d = shape_0;
                        nsteps_d = n_steps;
                        row_d    = '0;
                        step_d   = '0;
                        ovf_d    = 1'b0;
                        tmo_d    = 1'b0;
                        state_d  = zero_job ? ST_DONE : ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (pipe_data_ready) begin
                        wr_data_d = pipe_out_acc;
                        state_d   = ST_WRITE;
                    end else if (wdog_expired) begin
                        tmo_d   = 1'b1;
                        state_d = ST_ABORT;
                    end
                end
                ST_WRITE: begin
                    if (last_row) begin
                        row_d   = '0;
                        state_d = ST_STEP_END;
                    end else begin
                        row_d   = row_q + MAX_DIM'(1);
                        state_d = ST_WAIT;
                    end
                end
                ST_STEP_END: begin
                    if (last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_LAUNCH;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ABORT: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        // Overflow is only an error while a row is in flight; the solve carries on.
        if (pipe_overflow && ((state_q == ST_WAIT) || (state_q == ST_WRITE))) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shape0_q  <= '0;
            nsteps_q  <= '0;
            row_q     <= '0;
            step_q    <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shape0_q  <= shape0_d;
            nsteps_q  <= nsteps_d;
            row_q     <= row_d;
            step_q    <= step_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    assign pipe_start          = (state_q == ST_LAUNCH);
    assign pipe_final_done     = (state_q == ST_STEP_END) || (state_q == ST_ABORT);
    assign pipe_return_default = (state_q == ST_WRITE) || (state_q == ST_ABORT);
    assign wr_en               = (state_q == ST_WRITE);
    assign wr_addr             = ADD_SIZE'(RES_BASE) + ADD_SIZE'(row_q);
    assign wr_data             = wr_data_q;
    assign row_idx             = row_q;
    assign step_idx            = step_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = (state_q == ST_DONE);
    assign err_overflow        = ovf_q;
    assign err_timeout         = tmo_q;
    assign state_dbg           = state_q;

endmodule
